// File: rtl/score_display.sv
// ---------------------------------------------------------------------------
// score_display
//
// Shows two 0..99 player scores on a 4-digit multiplexed, common-anode
// 7-segment display. The scoring player's digits flash after each point.
//
// Each score is clamped to 99. A sequential double-dabble engine converts it
// to two BCD digits. Both players are converted in parallel lanes, which
// share one IDLE/SHIFT/LATCH controller.
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous, active-high
//   score1         in   [6:0] player-1 score, binary
//   score2         in   [6:0] player-2 score, binary
//   increaseScore  in   [1:0] one-cycle point pulse
//                       bit 0 = player 1 scored, bit 1 = player 2 scored
//   an             out  [3:0] digit anodes, active-low, one-hot
//   seg            out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   busy           out  high while a BCD conversion is in progress
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   When the macro is defined, a tens digit of 0 is blanked. The default
//   build always shows the tens digit.
// ---------------------------------------------------------------------------
module score_display #(
    parameter int DIGIT_PERIOD = 100000,
    parameter int FLASH_TOGGLE = 12500000,
    parameter int FLASH_PHASES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] score1,
    input  logic [6:0] score2,
    input  logic [1:0] increaseScore,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       busy
);

    localparam int SCAN_W = $clog2(DIGIT_PERIOD);
    localparam int TOG_W  = $clog2(FLASH_TOGGLE + 1);
    localparam int PH_W   = $clog2(FLASH_PHASES + 1);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(DIGIT_PERIOD - 1);
    localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);
    localparam logic [TOG_W-1:0]  TOG_LOAD  = TOG_W'(FLASH_TOGGLE);
    localparam logic [TOG_W-1:0]  TOG_ONE   = TOG_W'(1);
    localparam logic [PH_W-1:0]   PH_LOAD   = PH_W'(FLASH_PHASES);
    localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    // ---------------------------------------------------------------------
    // Conversion controller
    // ---------------------------------------------------------------------
    state_t     state_reg, state_next;
    logic [2:0] shift_cnt_reg;
    logic       load_en, shift_en, latch_en;
    logic [1:0] changed;

    // Lane 0 is player 1 and lane 1 is player 2.
    logic [1:0][6:0] score_bin;
    logic [1:0][3:0] tens_digit;
    logic [1:0][3:0] ones_digit;

    assign score_bin = {score2, score1};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            shift_cnt_reg <= 3'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == SHIFT)
                shift_cnt_reg <= shift_cnt_reg + 3'd1;
            else
                shift_cnt_reg <= 3'd0;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|changed) state_next = SHIFT;
            SHIFT:   if (shift_cnt_reg == 3'd6) state_next = LATCH;   // 7th shift
            LATCH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_reg != IDLE);
        load_en  = (state_reg == IDLE) && (|changed);
        shift_en = (state_reg == SHIFT);
        latch_en = (state_reg == LATCH);
    end

    // ---------------------------------------------------------------------
    // Per-player clamp, snapshot and double-dabble lane
    // dd_reg layout: [14:11] tens, [10:7] ones, [6:0] binary being shifted out
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [6:0]  clamped;
            logic [6:0]  snap_reg;
            logic [14:0] dd_reg;
            logic [14:0] dd_adj;
            logic [3:0]  tens_reg;
            logic [3:0]  ones_reg;

            assign clamped     = (score_bin[gi] > 7'd99) ? 7'd99 : score_bin[gi];
            assign changed[gi] = (clamped != snap_reg);

            always_comb begin
                dd_adj = dd_reg;
                if (dd_reg[10:7] >= 4'd5)
                    dd_adj[10:7] = dd_reg[10:7] + 4'd3;
                if (dd_reg[14:11] >= 4'd5)
                    dd_adj[14:11] = dd_reg[14:11] + 4'd3;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    snap_reg <= 7'd0;
                    dd_reg   <= 15'd0;
                    tens_reg <= 4'd0;
                    ones_reg <= 4'd0;
                end else begin
                    if (load_en) begin
                        snap_reg <= clamped;
                        dd_reg   <= {8'd0, clamped};
                    end else if (shift_en) begin
                        dd_reg <= {dd_adj[13:0], 1'b0};
                    end
                    if (latch_en) begin
                        tens_reg <= dd_reg[14:11];
                        ones_reg <= dd_reg[10:7];
                    end
                end
            end

            assign tens_digit[gi] = tens_reg;
            assign ones_digit[gi] = ones_reg;
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Digit scan
    // ---------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt_reg;
    logic [1:0]        idx_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_reg <= '0;
            idx_reg      <= 2'd0;
        end else if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_reg <= '0;
            idx_reg      <= idx_reg + 2'd1;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + SCAN_ONE;
        end
    end

    // ---------------------------------------------------------------------
    // Flash control. mask bit 0 is player 1 and bit 1 is player 2. Digits
    // are blanked while phase_reg is odd. Phases count down from an even
    // value, so each flash starts with the digits shown.
    // ---------------------------------------------------------------------
    logic [1:0]       mask_reg;
    logic [PH_W-1:0]  phase_reg;
    logic [TOG_W-1:0] timer_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_reg  <= 2'b00;
            phase_reg <= '0;
            timer_reg <= '0;
        end else if (|increaseScore) begin
            mask_reg  <= increaseScore;
            phase_reg <= PH_LOAD;
            timer_reg <= TOG_LOAD;
        end else if (phase_reg != '0) begin
            if (timer_reg == TOG_ONE) begin
                phase_reg <= phase_reg - PH_ONE;
                if (phase_reg == PH_ONE) begin
                    mask_reg  <= 2'b00;
                    timer_reg <= '0;
                end else begin
                    timer_reg <= TOG_LOAD;
                end
            end else begin
                timer_reg <= timer_reg - TOG_ONE;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Segment decode and registered outputs
    // ---------------------------------------------------------------------
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = SEG_BLANK;
        endcase
    endfunction

    logic [3:0] digit_sel;
    logic       in_mask;
    logic       zero_blank;
    logic [3:0] an_next;
    logic [6:0] seg_next;
    logic [3:0] an_reg;
    logic [6:0] seg_reg;

    // Indices 2 and 3 belong to player 1 (lane 0). Odd indices are tens digits.
    always_comb begin
        digit_sel = idx_reg[0] ? tens_digit[idx_reg[1] ? 0 : 1]
                               : ones_digit[idx_reg[1] ? 0 : 1];
        in_mask   = idx_reg[1] ? mask_reg[0] : mask_reg[1];
`ifdef LEADING_ZERO_BLANK_EN
        zero_blank = idx_reg[0] && (digit_sel == 4'd0);
`else
        zero_blank = 1'b0;
`endif
        an_next  = ~(4'b0001 << idx_reg);
        seg_next = ((phase_reg[0] && in_mask) || zero_blank) ? SEG_BLANK
                                                             : decode(digit_sel);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an_reg  <= 4'b1111;
            seg_reg <= SEG_BLANK;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;

endmodule
